// File: rtl/fa_bist_pkg.sv
// Shared types and helpers for the full-adder BIST engine.
//
// Contents:
//   state_e     - engine FSM states (idle, drive vector, sample outputs, done)
//   VEC_COUNT   - number of exhaustive input vectors for a 1-bit full adder
//   VEC_W       - width of the {a,b,cin} vector
//   ERR_W       - width of the error counter (holds 0..VEC_COUNT without wrap)
//   CNT_W       - width of the settle-cycle counter (SETTLE_CYCLES up to 15)
//   fa_expected - golden {s,cout} for a given {a,b,cin} vector
package fa_bist_pkg;

  localparam int unsigned VEC_COUNT = 8;
  localparam int unsigned VEC_W     = 3;
  localparam int unsigned ERR_W     = 4;
  localparam int unsigned CNT_W     = 4;

  typedef enum logic [1:0] {
    StIdle,
    StDrive,
    StSample,
    StDone
  } state_e;

  // vec is {a,b,cin} with a as the MSB; result is {s_exp, cout_exp}.
  function automatic logic [1:0] fa_expected(input logic [VEC_W-1:0] vec);
    logic op_a, op_b, op_c;
    op_a = vec[2];
    op_b = vec[1];
    op_c = vec[0];
    return {op_a ^ op_b ^ op_c, (op_a & op_b) | (op_a & op_c) | (op_b & op_c)};
  endfunction

endpackage

// File: rtl/fa_golden.sv
// Combinational golden comparator for one full-adder vector.
//
// Ports:
//   vec_i      - {a,b,cin} vector currently applied to the adder under test
//   s_i        - observed sum
//   cout_i     - observed carry
//   mismatch_o - 1 when observed {s,cout} differs from the golden value
//
// The compare uses case inequality so an X/Z on s or cout is flagged as a
// mismatch in simulation; synthesis treats it as an ordinary inequality.
module fa_golden
  import fa_bist_pkg::*;
(
  input  logic [VEC_W-1:0] vec_i,
  input  logic             s_i,
  input  logic             cout_i,
  output logic             mismatch_o
);

  always_comb begin
    mismatch_o = ({s_i, cout_i} !== fa_expected(vec_i));
  end

endmodule

// File: rtl/full_adder_bist.sv
// Built-in self-test engine for a single Full_Adder cell.
//
// Walks all eight {a,b,cin} vectors in ascending order, holds each for
// SETTLE_CYCLES cycles, samples s/cout for one cycle and compares them with
// the golden model. Reports pass/fail, an error count and the first failing
// vector. All outputs are registered.
//
// Parameters:
//   SETTLE_CYCLES - cycles each vector is held before sampling (legal 1..15)
//
// Ports:
//   clk        - system clock, rising edge
//   rst        - synchronous active-high reset
//   start      - begin a run; only honoured while idle
//   s, cout    - outputs of the adder under test
//   a, b, cin  - operands driven to the adder under test (0 when idle/done)
//   busy       - high from start acceptance until the done state is left
//   done       - one-cycle pulse at the end of a run
//   pass       - run result, valid from done and held until the next start
//   err_count  - number of mismatching vectors (0..8)
//   fail_valid - at least one mismatch seen this run
//   first_fail - {a,b,cin} of the first mismatching vector
//   fail_map   - per-vector mismatch bitmap (only with FA_BIST_FAIL_MAP_EN)
//
// Build option:
//   FA_BIST_FAIL_MAP_EN - when defined, adds the fail_map output and its register.
module full_adder_bist
  import fa_bist_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 s,
  input  logic                 cout,
  output logic                 a,
  output logic                 b,
  output logic                 cin,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic [ERR_W-1:0]     err_count,
  output logic                 fail_valid,
  output logic [VEC_W-1:0]     first_fail
`ifdef FA_BIST_FAIL_MAP_EN
  ,
  output logic [VEC_COUNT-1:0] fail_map
`endif
);

  localparam logic [CNT_W-1:0] CntLast = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [VEC_W-1:0] VecLast = VEC_W'(VEC_COUNT - 1);

  state_e           state_q, state_d;
  logic [VEC_W-1:0] vec_q, vec_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [ERR_W-1:0] err_q, err_d;
  logic             fail_valid_q, fail_valid_d;
  logic [VEC_W-1:0] first_fail_q, first_fail_d;
  logic             pass_q, pass_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [VEC_W-1:0] abc_q, abc_d;
`ifdef FA_BIST_FAIL_MAP_EN
  logic [VEC_COUNT-1:0] fail_map_q, fail_map_d;
`endif

  logic mismatch;

  fa_golden u_golden (
    .vec_i      (vec_q),
    .s_i        (s),
    .cout_i     (cout),
    .mismatch_o (mismatch)
  );

  always_comb begin
    state_d      = state_q;
    vec_d        = vec_q;
    cnt_d        = cnt_q;
    err_d        = err_q;
    fail_valid_d = fail_valid_q;
    first_fail_d = first_fail_q;
    pass_d       = pass_q;
`ifdef FA_BIST_FAIL_MAP_EN
    fail_map_d   = fail_map_q;
`endif

    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d      = StDrive;
          vec_d        = '0;
          cnt_d        = '0;
          err_d        = '0;
          fail_valid_d = 1'b0;
          first_fail_d = '0;
          pass_d       = 1'b0;
`ifdef FA_BIST_FAIL_MAP_EN
          fail_map_d   = '0;
`endif
        end
      end

      StDrive: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CntLast) begin
          state_d = StSample;
        end
      end

      StSample: begin
        if (mismatch) begin
          // At most VEC_COUNT increments per run, so the counter cannot wrap.
          err_d = err_q + 1'b1;
          if (!fail_valid_q) begin
            fail_valid_d = 1'b1;
            first_fail_d = vec_q;
          end
`ifdef FA_BIST_FAIL_MAP_EN
          fail_map_d[vec_q] = 1'b1;
`endif
        end
        if (vec_q == VecLast) begin
          state_d = StDone;
          // Uses err_d so a mismatch on the last vector is included.
          pass_d  = (err_d == '0);
        end else begin
          state_d = StDrive;
          vec_d   = vec_q + 1'b1;
          cnt_d   = '0;
        end
      end

      StDone: begin
        state_d = StIdle;
      end

      default: begin
        state_d = StIdle;
      end
    endcase

    // Outputs are derived from the next state so they are registered yet
    // line up with the state they describe.
    busy_d = (state_d != StIdle);
    done_d = (state_d == StDone);
    abc_d  = ((state_d == StDrive) || (state_d == StSample)) ? vec_d : '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      vec_q        <= '0;
      cnt_q        <= '0;
      err_q        <= '0;
      fail_valid_q <= 1'b0;
      first_fail_q <= '0;
      pass_q       <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      abc_q        <= '0;
`ifdef FA_BIST_FAIL_MAP_EN
      fail_map_q   <= '0;
`endif
    end else begin
      state_q      <= state_d;
      vec_q        <= vec_d;
      cnt_q        <= cnt_d;
      err_q        <= err_d;
      fail_valid_q <= fail_valid_d;
      first_fail_q <= first_fail_d;
      pass_q       <= pass_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      abc_q        <= abc_d;
`ifdef FA_BIST_FAIL_MAP_EN
      fail_map_q   <= fail_map_d;
`endif
    end
  end

  assign a          = abc_q[2];
  assign b          = abc_q[1];
  assign cin        = abc_q[0];
  assign busy       = busy_q;
  assign done       = done_q;
  assign pass       = pass_q;
  assign err_count  = err_q;
  assign fail_valid = fail_valid_q;
  assign first_fail = first_fail_q;
`ifdef FA_BIST_FAIL_MAP_EN
  assign fail_map   = fail_map_q;
`endif

endmodule

// File: tb/tb_full_adder_bist.sv
// Self-checking bench for full_adder_bist.
//
// Two engines (SETTLE_CYCLES = 2 and 1) share clock, reset and start. Each
// drives its own behavioural full adder whose s/cout can be flipped per
// vector to inject faults. Expected results come from plain arithmetic
// (a+b+cin) over all eight vectors.
module tb_full_adder_bist;

  logic clk = 1'b0;
  logic rst;
  logic start;
  logic [7:0] flip_s, flip_c;

  logic a0, b0, c0, s0, co0, busy0, done0, pass0, fv0;
  logic [3:0] err0;
  logic [2:0] ff0;
  logic a1, b1, c1, s1, co1, busy1, done1, pass1, fv1;
  logic [3:0] err1;
  logic [2:0] ff1;
`ifdef FA_BIST_FAIL_MAP_EN
  logic [7:0] map0, map1;
`endif

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  // Behavioural full adder with optional per-vector output inversion.
  function automatic logic [1:0] fa_dut(input logic [2:0] v, input logic [7:0] fs,
                                        input logic [7:0] fc);
    int sum;
    sum = int'(v[2]) + int'(v[1]) + int'(v[0]);
    return {sum[0] ^ fs[v], sum[1] ^ fc[v]};
  endfunction

  assign {s0, co0} = fa_dut({a0, b0, c0}, flip_s, flip_c);
  assign {s1, co1} = fa_dut({a1, b1, c1}, flip_s, flip_c);

  full_adder_bist #(.SETTLE_CYCLES(2)) u_dut0 (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .s          (s0),
    .cout       (co0),
    .a          (a0),
    .b          (b0),
    .cin        (c0),
    .busy       (busy0),
    .done       (done0),
    .pass       (pass0),
    .err_count  (err0),
    .fail_valid (fv0),
    .first_fail (ff0)
`ifdef FA_BIST_FAIL_MAP_EN
    ,
    .fail_map   (map0)
`endif
  );

  full_adder_bist #(.SETTLE_CYCLES(1)) u_dut1 (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .s          (s1),
    .cout       (co1),
    .a          (a1),
    .b          (b1),
    .cin        (c1),
    .busy       (busy1),
    .done       (done1),
    .pass       (pass1),
    .err_count  (err1),
    .fail_valid (fv1),
    .first_fail (ff1)
`ifdef FA_BIST_FAIL_MAP_EN
    ,
    .fail_map   (map1)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Packed view of every reset-valued output of each engine.
  function automatic logic [13:0] outs0();
    return {busy0, done0, pass0, err0, fv0, ff0, a0, b0, c0};
  endfunction
  function automatic logic [13:0] outs1();
    return {busy1, done1, pass1, err1, fv1, ff1, a1, b1, c1};
  endfunction

  // Reference: which vectors of the faulty adder disagree with a+b+cin.
  function automatic logic [7:0] ref_map(input logic [7:0] fs, input logic [7:0] fc);
    logic [7:0] m;
    int sum;
    m = '0;
    for (int v = 0; v < 8; v++) begin
      sum = (v >> 2 & 1) + (v >> 1 & 1) + (v & 1);
      if (fa_dut(3'(v), fs, fc) != {sum[0], sum[1]}) m[v] = 1'b1;
    end
    return m;
  endfunction

  function automatic int first_set(input logic [7:0] m);
    for (int v = 0; v < 8; v++) if (m[v]) return v;
    return 0;
  endfunction

  // One run: pulse start, optionally pulse start again mid-run (vector 4 of
  // the slow engine) and optionally assert rst before edge rst_at.
  task automatic run(input string tag, input logic [7:0] fs, input logic [7:0] fc,
                     input bit mid_pulse, input int rst_at);
    logic [7:0] m;
    int exp_err, exp_first, d0_n, d0_k, d1_n, d1_k, bad_order;
    m         = ref_map(fs, fc);
    exp_err   = $countones(m);
    exp_first = first_set(m);
    d0_n = 0; d0_k = -1; d1_n = 0; d1_k = -1; bad_order = 0;
    flip_s = fs;
    flip_c = fc;

    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    check({tag, "/busy_at_accept"}, 32'({busy0, busy1}), 32'b11);
    check({tag, "/abc_at_accept"}, 32'({a0, b0, c0}), 32'd0);

    for (int k = 1; k <= 32; k++) begin
      if (mid_pulse && k == 12) start = 1'b1;
      if (mid_pulse && k == 13) start = 1'b0;
      if (k == rst_at) rst = 1'b1;
      if (rst_at > 0 && k == rst_at - 1) begin
        check({tag, "/pending_err"}, 32'(err0), 32'($countones(m & 8'h1f)));
      end
      @(posedge clk);
      #1;
      if (k == rst_at) begin
        rst = 1'b0;
        check({tag, "/rst_outs0"}, 32'(outs0()), 32'd0);
        check({tag, "/rst_outs1"}, 32'(outs1()), 32'd0);
      end
      if (rst_at < 0 && k <= 24) begin
        if ({a0, b0, c0} !== ((k < 24) ? 3'(k / 3) : 3'd0)) bad_order++;
      end
      if (done0) begin
        d0_n++;
        d0_k = k;
        check({tag, "/busy0_at_done"}, 32'(busy0), 32'd1);
        check({tag, "/pass0"}, 32'(pass0), 32'(exp_err == 0));
        check({tag, "/err0"}, 32'(err0), 32'(exp_err));
        check({tag, "/fv0"}, 32'(fv0), 32'(exp_err != 0));
        if (exp_err != 0) check({tag, "/first0"}, 32'(ff0), 32'(exp_first));
`ifdef FA_BIST_FAIL_MAP_EN
        check({tag, "/map0"}, 32'(map0), 32'(m));
`endif
      end
      if (done1) begin
        d1_n++;
        d1_k = k;
        check({tag, "/pass1"}, 32'(pass1), 32'(exp_err == 0));
        check({tag, "/err1"}, 32'(err1), 32'(exp_err));
        if (exp_err != 0) check({tag, "/first1"}, 32'(ff1), 32'(exp_first));
      end
      if (rst_at < 0 && k == 25) begin
        check({tag, "/idle_after_done"}, 32'({busy0, done0}), 32'd0);
      end
    end

    if (rst_at < 0) begin
      check({tag, "/done0_count"}, 32'(d0_n), 32'd1);
      check({tag, "/done0_latency"}, 32'(d0_k), 32'd24);
      check({tag, "/done1_count"}, 32'(d1_n), 32'd1);
      check({tag, "/done1_latency"}, 32'(d1_k), 32'd16);
      check({tag, "/vec_order"}, 32'(bad_order), 32'd0);
      check({tag, "/pass0_held"}, 32'({pass0, err0}), 32'({exp_err == 0, 4'(exp_err)}));
    end else begin
      check({tag, "/no_done0"}, 32'(d0_n), 32'd0);
      check({tag, "/done1_count"}, 32'(d1_n), 32'(rst_at > 16));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst    = 1'b1;
    start  = 1'b0;
    flip_s = '0;
    flip_c = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_outs0", 32'(outs0()), 32'd0);
    check("reset_outs1", 32'(outs1()), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    run("healthy", 8'h00, 8'h00, 1'b0, -1);
    run("s_stuck0", 8'b1001_0110, 8'h00, 1'b0, -1);
    run("cout_inv", 8'h00, 8'hff, 1'b0, -1);
    run("mid_start", 8'b1001_0110, 8'h00, 1'b1, -1);
    run("healthy_after", 8'h00, 8'h00, 1'b0, -1);
    run("rst_sample5", 8'b1001_0110, 8'h00, 1'b0, 18);
    run("after_rst", 8'h00, 8'h00, 1'b0, -1);

    // rst wins over start while idle.
    @(negedge clk);
    rst   = 1'b1;
    start = 1'b1;
    @(posedge clk);
    #1;
    check("rst_start_busy", 32'({busy0, busy1}), 32'd0);
    check("rst_start_outs0", 32'(outs0()), 32'd0);
    rst   = 1'b0;
    start = 1'b0;

    for (int i = 0; i < 4; i++) begin
      run("random", 8'($urandom), 8'($urandom & $urandom), 1'b0, -1);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
